bcd_updown_counter_nd: RTL and testbench
========================================

# bcd_updown_counter_nd

Parametrised multi-digit BCD up/down counter, the successor to the single-digit BCD up/down counter. It counts 0 to 10^DIGITS−1 in packed BCD, with count enable, direction control, parallel load with BCD validity checking, and a selectable wrap or saturate mode at the range ends. It provides a combinational terminal-count output for cascading and registered overflow/underflow pulses. Intended for display/timekeeping datapaths feeding 7-segment decoders.

## Interface
- DIGITS, 4, number of BCD digits (1..8); counter range 0 .. 10^DIGITS−1
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; synchronous and active-high, sampled on rising edge of clk
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load request
- load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0]
- q  output  4*DIGITS  packed BCD count; digit i in bits [4i+3:4i]
- tc  output  1  terminal count (combinational)
- ovf  output  1  one-cycle pulse: up-count attempted from all-9s
- unf  output  1  one-cycle pulse: down-count attempted from all-0s
- load_err  output  1  one-cycle pulse: load rejected (invalid BCD digit)

## Operation
- Priority per rising edge: rst > load > en > hold.
- rst=1: q=0, ovf=0, unf=0, load_err=0.
- load=1 (en ignored): if every 4-bit digit of load_val is ≤9, q<=load_val and load_err<=0. Otherwise q is unchanged and load_err<=1. ovf and unf are 0 on any load cycle.
- en=1, load=0, up=1:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit. A digit receiving a carry follows the same rule.
  - If q is all 9s: SATURATE=0 gives q<=0; SATURATE=1 leaves q unchanged. In both modes ovf<=1.
- en=1, load=0, up=0:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - If q is all 0s: SATURATE=0 gives q<=all 9s; SATURATE=1 leaves q unchanged. In both modes unf<=1.
- en=0, load=0: q holds; ovf, unf and load_err are 0.
- ovf, unf and load_err are 0 on every cycle in which their condition is not met. They are never held high.
- tc = en & ~load & (up ? (q == all 9s) : (q == all 0s)). This is purely combinational and is used as the en of a downstream cascaded counter.
- Digit values never leave 0..9 under any input sequence after reset.
- Before the first reset, q is undefined. Benches must apply rst first.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on q after edge N.
- ovf, unf and load_err are registered. They go high after the same edge that performs the wrap/hold or rejection, and stay high for exactly one cycle.
- tc is valid in the same cycle as its inputs, with no register. A cascade of two instances sharing clk therefore advances the upper instance on the same edge that the lower one wraps.
- Reset mid-count: q=0 after the reset edge regardless of en, load or up. A pending flag is cleared.
- Reversing direction on consecutive cycles is legal; each edge applies the then-current up.
- load and en together: load wins, and no count occurs that cycle.

## Test plan
- Reset then up-count (DIGITS=4): rst for 1 cycle, then en=1, up=1 for 12 cycles -> q goes 0000,0001..0009,0010,0011,0012. Digit 0 never shows A..F.
- Up wrap, SATURATE=0: load 9998, then en=1, up=1 for 3 cycles -> q=9999, 0000, 0001. tc=1 only in the cycle q=9999. ovf=1 only in the cycle after 9999→0000.
- Down wrap and saturate: SATURATE=0, load 0001, down ×2 -> q=0000 then 9999, with unf pulse after the second edge. Then SATURATE=1, load 0000, down ×3 -> q stays 0000 and unf=1 on each of the 3 cycles.
- Load validation: load 1234 -> q=1234, load_err=0. Then load 12A4 -> q stays 1234 and load_err pulses for 1 cycle. Then load=1 with en=1, up=1 and load_val=0500 -> q=0500 (no increment).
- Carry chain and direction change: load 0999, up 1 cycle -> 1000. Down 1 cycle -> 0999. Down with en=0 for 5 cycles -> q holds 0999, all flags 0.
- Reset mid-operation: counting up at 4567, assert rst with load=1, en=1 -> q=0000 and flags 0 after that edge. Deassert rst -> counting resumes from 0001.

Source files
------------

// File: rtl/bcd_updown_counter_nd.sv
// bcd_updown_counter_nd
//
// Multi-digit packed-BCD up/down counter with parallel load and BCD validity
// checking. The count range is 0 .. 10^DIGITS-1. At the range ends the
// counter either wraps or holds, depending on SATURATE.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8)
//   SATURATE : 0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk      : clock; all state updates happen on the rising edge
//   rst      : synchronous active-high reset
//   en       : count enable
//   up       : direction (1 = increment, 0 = decrement)
//   load     : parallel load request (overrides en)
//   load_val : packed BCD load value, digit 0 in bits [3:0]
//   q        : packed BCD count, digit i in bits [4i+3:4i]
//   tc       : combinational terminal count, drives en of a cascaded stage
//   ovf      : one-cycle pulse, up-count attempted from all 9s
//   unf      : one-cycle pulse, down-count attempted from all 0s
//   load_err : one-cycle pulse, load rejected because a digit was above 9
//
// Edge priority: rst > load > en > hold.
// There is no valid/ready handshake. A request (load or en) is taken on the
// edge where it is sampled high, and its result shows on q after that edge.
module bcd_updown_counter_nd #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                ovf,
  output logic                unf,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic         all9;
  logic         all0;
  logic         load_ok;
  logic         carry;
  logic         borrow;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;

  // Ripple the carry and the borrow from digit 0 upward.
  // From all 9s the incremented value is all 0s. From all 0s the decremented
  // value is all 9s. The wrap mode therefore needs no extra logic; only the
  // saturate mode must suppress the update.
  always_comb begin
    all9    = 1'b1;
    all0    = 1'b1;
    load_ok = 1'b1;
    carry   = 1'b1;
    borrow  = 1'b1;
    inc_val = '0;
    dec_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (q[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (q[4*i +: 4] != 4'd0) all0 = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;

      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = q[4*i +: 4];
      end

      if (borrow) begin
        if (q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = q[4*i +: 4];
      end
    end
  end

  // The terminal count has no register, so that a cascaded upper stage
  // advances on the same edge on which this stage wraps.
  assign tc = en & ~load & (up ? all9 : all0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) q <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
        if (up) begin
          if (all9) ovf <= 1'b1;
          if (!(SATURATE && all9)) q <= inc_val;
        end else begin
          if (all0) unf <= 1'b1;
          if (!(SATURATE && all0)) q <= dec_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Bench for bcd_updown_counter_nd. Two instances share all inputs: one in
// wrap mode and one in saturate mode. A behavioural model holds each count
// as a plain integer and converts it to packed BCD for comparison.
module tb_bcd_updown_counter_nd;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] q0, q1;
  logic         tc0, tc1, ovf0, ovf1, unf0, unf1, lerr0, lerr1;

  bcd_updown_counter_nd #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q0), .tc(tc0), .ovf(ovf0), .unf(unf0), .load_err(lerr0)
  );

  bcd_updown_counter_nd #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q1), .tc(tc1), .ovf(ovf1), .unf(unf1), .load_err(lerr1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  // Behavioural model. Index 0 is the wrap instance, index 1 the saturate one.
  int m_val[2];
  bit m_ovf[2], m_unf[2], m_lerr[2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_val[s] = 0; m_ovf[s] = 0; m_unf[s] = 0; m_lerr[s] = 0;
      end else begin
        m_ovf[s] = 0; m_unf[s] = 0; m_lerr[s] = 0;
        if (load) begin
          if (bcd_ok(load_val)) m_val[s] = from_bcd(load_val);
          else m_lerr[s] = 1;
        end else if (en) begin
          if (up) begin
            if (m_val[s] == MAXV) begin
              m_ovf[s] = 1;
              if (s == 0) m_val[s] = 0;
            end else m_val[s] = m_val[s] + 1;
          end else begin
            if (m_val[s] == 0) begin
              m_unf[s] = 1;
              if (s == 0) m_val[s] = MAXV;
            end else m_val[s] = m_val[s] - 1;
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Compare on every falling edge, once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("q_wrap",   32'(q0),    32'(to_bcd(m_val[0])));
      chk("q_sat",    32'(q1),    32'(to_bcd(m_val[1])));
      chk("ovf_wrap", 32'(ovf0),  32'(m_ovf[0]));
      chk("ovf_sat",  32'(ovf1),  32'(m_ovf[1]));
      chk("unf_wrap", 32'(unf0),  32'(m_unf[0]));
      chk("unf_sat",  32'(unf1),  32'(m_unf[1]));
      chk("lerr_wrap", 32'(lerr0), 32'(m_lerr[0]));
      chk("lerr_sat",  32'(lerr1), 32'(m_lerr[1]));
      chk("tc_wrap", 32'(tc0), 32'(en & ~load & (up ? (m_val[0] == MAXV) : (m_val[0] == 0))));
      chk("tc_sat",  32'(tc1), 32'(en & ~load & (up ? (m_val[1] == MAXV) : (m_val[1] == 0))));
    end
  end

  // Driver: apply the inputs, then move to 1 time unit after the next rising
  // edge, so the result of that edge is visible on return.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input logic [W-1:0] lv);
    rst = r; load = l; en = e; up = u; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation for a DUT value, also checked against the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] model);
    chk({name, "_dut"}, act, exp);
    chk({name, "_model"}, model, exp);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // reset, then count up
    cyc(1, 0, 0, 0, '0);
    lit("rst_q", 32'(q0), 32'h0000, 32'(to_bcd(m_val[0])));
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1, '0);
      if (i == 8)  lit("up9",  32'(q0), 32'h0009, 32'(to_bcd(m_val[0])));
      if (i == 9)  lit("up10", 32'(q0), 32'h0010, 32'(to_bcd(m_val[0])));
      if (i == 11) lit("up12", 32'(q0), 32'h0012, 32'(to_bcd(m_val[0])));
    end

    // up wrap / saturate
    cyc(0, 1, 0, 0, 16'h9998);
    cyc(0, 0, 1, 1, '0);
    lit("q9999", 32'(q0), 32'h9999, 32'(to_bcd(m_val[0])));
    lit("tc9999", 32'(tc0), 32'h1, 32'(en & ~load & up & (m_val[0] == MAXV)));
    cyc(0, 0, 1, 1, '0);
    lit("wrap0", 32'(q0), 32'h0000, 32'(to_bcd(m_val[0])));
    lit("ovf_pulse", 32'(ovf0), 32'h1, 32'(m_ovf[0]));
    lit("sat_hold", 32'(q1), 32'h9999, 32'(to_bcd(m_val[1])));
    cyc(0, 0, 1, 1, '0);
    lit("wrap1", 32'(q0), 32'h0001, 32'(to_bcd(m_val[0])));
    lit("ovf_drop", 32'(ovf0), 32'h0, 32'(m_ovf[0]));

    // down wrap
    cyc(0, 1, 0, 0, 16'h0001);
    cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, '0);
    lit("dwrap", 32'(q0), 32'h9999, 32'(to_bcd(m_val[0])));
    lit("unf_pulse", 32'(unf0), 32'h1, 32'(m_unf[0]));

    // down saturate
    cyc(0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, '0);
      lit("sat0", 32'(q1), 32'h0000, 32'(to_bcd(m_val[1])));
      lit("sat_unf", 32'(unf1), 32'h1, 32'(m_unf[1]));
    end

    // load validation
    cyc(0, 1, 0, 0, 16'h1234);
    lit("ld1234", 32'(q0), 32'h1234, 32'(to_bcd(m_val[0])));
    cyc(0, 1, 0, 0, 16'h12A4);
    lit("ld_bad_q", 32'(q0), 32'h1234, 32'(to_bcd(m_val[0])));
    lit("ld_err", 32'(lerr0), 32'h1, 32'(m_lerr[0]));
    cyc(0, 1, 1, 1, 16'h0500);
    lit("ld_wins", 32'(q0), 32'h0500, 32'(to_bcd(m_val[0])));
    lit("ld_err_drop", 32'(lerr0), 32'h0, 32'(m_lerr[0]));

    // carry chain and direction change
    cyc(0, 1, 0, 0, 16'h0999);
    cyc(0, 0, 1, 1, '0);
    lit("carry", 32'(q0), 32'h1000, 32'(to_bcd(m_val[0])));
    cyc(0, 0, 1, 0, '0);
    lit("borrow", 32'(q0), 32'h0999, 32'(to_bcd(m_val[0])));
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0);
    lit("hold", 32'(q0), 32'h0999, 32'(to_bcd(m_val[0])));

    // reset in the middle of counting
    cyc(0, 1, 0, 0, 16'h4567);
    cyc(0, 0, 1, 1, '0);
    cyc(1, 1, 1, 1, 16'h1111);
    lit("mid_rst", 32'(q0), 32'h0000, 32'(to_bcd(m_val[0])));
    cyc(0, 0, 1, 1, '0);
    lit("resume", 32'(q0), 32'h0001, 32'(to_bcd(m_val[0])));

    // random stimulus
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] lv;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) lv = W'($urandom);
      else if (sel < 3) lv = ($urandom_range(0, 1) != 0) ? to_bcd(MAXV - int'($urandom_range(0, 2)))
                                                         : to_bcd(int'($urandom_range(0, 2)));
      else lv = to_bcd(int'($urandom_range(0, MAXV)));
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1,
          lv);
    end

    cyc(0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
